display_scheduler: RTL and testbench

Sequencing controller that sits between the temperature/humidity sensor front end and the `seg7` two-digit display decoder. It accepts a binary temperature/humidity sample pair through a valid/ready handshake and converts each value to two decimal digit codes with a sequential divide-by-10 engine. It alternates the shown quantity on a dwell timer and time-multiplexes the two digits onto one shared digit-code bus for shared-segment display modules.

---
 rtl/display_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/display_scheduler.sv | 164 ++++++++++++++++
 tb/tb_display_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit display scheduler.
package display_pkg;

    // Code that the downstream segment decoder renders as "-".
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        CONV_T,
        CONV_H,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } digit_pair_t;

    localparam digit_pair_t DASH_PAIR = '{hi: DASH, lo: DASH};

    // Pick the tens (sel=0) or ones (sel=1) code out of a pair.
    function automatic logic [3:0] pick_digit(input logic sel, input digit_pair_t pair);
        return sel ? pair.lo : pair.hi;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit to two-digit converter: repeated subtract-10.
// Values of 100 or more finish in one cycle with a DASH/DASH result.
// 'done' is asserted for exactly the last cycle of a conversion; a new
// 'start' in that cycle reloads the engine without a gap.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  value,
    output logic        done,
    output digit_pair_t result
);

    logic [7:0] rem_reg;
    logic [3:0] tens_reg;
    logic       busy_reg;
    logic       overflow;
    logic       below_ten;

    // A loaded value >= 100 is the only way the remainder can be >= 100,
    // so the overflow test can be made on the remainder itself.
    assign overflow  = (rem_reg >= 8'd100);
    assign below_ten = (rem_reg < 8'd10);
    assign done      = busy_reg && (overflow || below_ten);

    // Result is valid whenever done is high.
    always_comb begin
        result = overflow ? DASH_PAIR : '{hi: tens_reg, lo: rem_reg[3:0]};
    end

    // Load on start, otherwise strip one ten per cycle until finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            tens_reg <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= value;
            tens_reg <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg && !done) begin
            rem_reg  <= rem_reg - 8'd10;
            tens_reg <= tens_reg + 4'd1;
        end else if (done) begin
            busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Accepts temperature/humidity samples, converts both to decimal digit
// pairs with one shared converter, alternates the shown quantity on a
// dwell timer and time-multiplexes the two digits onto digit_cur.
module display_scheduler
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int MUX_CYCLES   = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp_in,
    input  logic [7:0] hum_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       showing_hum,
    output logic       digit_sel,
    output logic [3:0] digit_cur
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int MW = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_CYCLES - 1);

    state_t      state_reg;
    logic        sample_ready_reg;
    logic [7:0]  hum_lat_reg;
    digit_pair_t temp_pend_reg;
    digit_pair_t hum_pend_reg;
    digit_pair_t temp_pair_reg;
    digit_pair_t hum_pair_reg;
    digit_pair_t shown_reg;
    logic        showing_hum_reg;
    logic        digit_sel_reg;
    logic [DW-1:0] dwell_cnt_reg;
    logic [MW-1:0] mux_cnt_reg;

    logic        handshake;
    logic        conv_start;
    logic [7:0]  conv_value;
    logic        conv_done;
    digit_pair_t conv_result;
    logic        dwell_wrap;
    logic        mux_wrap;
    logic        showing_hum_next;
    logic        commit;
    digit_pair_t temp_src;
    digit_pair_t hum_src;
    digit_pair_t shown_next;

    // Temperature goes straight from the port into the converter at the
    // handshake; humidity waits in hum_lat_reg until temperature is done.
    assign handshake  = (state_reg == IDLE) && sample_valid && sample_ready_reg;
    assign conv_start = handshake || ((state_reg == CONV_T) && conv_done);
    assign conv_value = (state_reg == IDLE) ? temp_in : hum_lat_reg;

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .value  (conv_value),
        .done   (conv_done),
        .result (conv_result)
    );

    assign dwell_wrap       = (dwell_cnt_reg == DWELL_LAST);
    assign mux_wrap         = (mux_cnt_reg == MUX_LAST);
    assign showing_hum_next = showing_hum_reg ^ dwell_wrap;
    assign commit           = (state_reg == COMMIT);

    // During COMMIT the display is fed from the pending pairs so new digits
    // show one cycle after COMMIT, for whichever quantity is shown next.
    always_comb begin
        temp_src   = commit ? temp_pend_reg : temp_pair_reg;
        hum_src    = commit ? hum_pend_reg  : hum_pair_reg;
        shown_next = showing_hum_next ? hum_src : temp_src;
    end

    // Sample sequencing FSM: latch, convert temp, convert hum, commit both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            sample_ready_reg <= 1'b1;
            hum_lat_reg      <= '0;
            temp_pend_reg    <= DASH_PAIR;
            hum_pend_reg     <= DASH_PAIR;
            temp_pair_reg    <= DASH_PAIR;
            hum_pair_reg     <= DASH_PAIR;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        hum_lat_reg      <= hum_in;
                        sample_ready_reg <= 1'b0;
                        state_reg        <= CONV_T;
                    end
                end
                CONV_T: begin
                    if (conv_done) begin
                        temp_pend_reg <= conv_result;
                        state_reg     <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (conv_done) begin
                        hum_pend_reg <= conv_result;
                        state_reg    <= COMMIT;
                    end
                end
                COMMIT: begin
                    temp_pair_reg    <= temp_pend_reg;
                    hum_pair_reg     <= hum_pend_reg;
                    sample_ready_reg <= 1'b1;
                    state_reg        <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Free-running dwell timer; toggles the shown quantity at wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt_reg   <= '0;
            showing_hum_reg <= 1'b0;
        end else begin
            dwell_cnt_reg   <= dwell_wrap ? '0 : dwell_cnt_reg + 1'b1;
            showing_hum_reg <= showing_hum_next;
        end
    end

    // Free-running digit multiplex timer; toggles the digit slot at wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt_reg   <= '0;
            digit_sel_reg <= 1'b0;
        end else begin
            mux_cnt_reg   <= mux_wrap ? '0 : mux_cnt_reg + 1'b1;
            digit_sel_reg <= digit_sel_reg ^ mux_wrap;
        end
    end

    // Registered display pair, always consistent with showing_hum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_reg <= DASH_PAIR;
        end else begin
            shown_reg <= shown_next;
        end
    end

    assign sample_ready = sample_ready_reg;
    assign showing_hum  = showing_hum_reg;
    assign digit_sel    = digit_sel_reg;
    assign digit_hi     = shown_reg.hi;
    assign digit_lo     = shown_reg.lo;
    assign digit_cur    = pick_digit(digit_sel_reg, shown_reg);

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized scoreboard bench for display_scheduler (dwell 8, mux 2).
module tb_display_scheduler;

    localparam int DWELL = 8;
    localparam int MUXC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] temp_in = '0;
    logic [7:0] hum_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic       showing_hum;
    logic       digit_sel;
    logic [3:0] digit_cur;

    display_scheduler #(.DWELL_CYCLES(DWELL), .MUX_CYCLES(MUXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .temp_in      (temp_in),
        .hum_in       (hum_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .digit_hi     (digit_hi),
        .digit_lo     (digit_lo),
        .showing_hum  (showing_hum),
        .digit_sel    (digit_sel),
        .digit_cur    (digit_cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tpair;
        logic [7:0] hpair;
        int         hs_t;
        int         lat;
        int         tv;
        int         hv;
    } txn_t;

    txn_t q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   t;              // clock edges since reset release
    logic [7:0] model_temp = 8'hAA;
    logic [7:0] model_hum  = 8'hAA;
    logic prev_ready = 1'b1;

    // Reference: decimal digits of v, or dash/dash when v has 3 digits.
    function automatic logic [7:0] ref_pair(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 100) return 8'hAA;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    function automatic int conv_time(input int v);
        return (v < 100) ? (v / 10 + 1) : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at t=%0d", name, act, exp, t);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    // Monitor: pops a transaction on each sample_ready rise and checks the
    // visible state against the model every cycle.
    always @(negedge clk) begin
        txn_t e;
        logic [7:0] exp_pair;
        int exp_show;
        int exp_sel;
        if (!rst_n) begin
            q.delete();
            model_temp = 8'hAA;
            model_hum  = 8'hAA;
            prev_ready = 1'b1;
            chk("reset_outputs", {sample_ready, digit_hi, digit_lo, showing_hum, digit_sel, digit_cur},
                {1'b1, 4'hA, 4'hA, 1'b0, 1'b0, 4'hA});
        end else begin
            if (sample_ready && !prev_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", t - e.hs_t, e.lat);
                    model_temp = e.tpair;
                    model_hum  = e.hpair;
                    $display("commit temp=%0d hum=%0d -> %h/%h at t=%0d", e.tv, e.hv, e.tpair, e.hpair, t);
                end
            end
            prev_ready = sample_ready;
            exp_show = (t / DWELL) % 2;
            exp_sel  = (t / MUXC) % 2;
            exp_pair = (exp_show != 0) ? model_hum : model_temp;
            chk("showing_hum", int'(showing_hum), exp_show);
            chk("digit_sel", int'(digit_sel), exp_sel);
            chk("digits", int'({digit_hi, digit_lo}), int'(exp_pair));
            chk("digit_cur", int'(digit_cur), (exp_sel != 0) ? int'(exp_pair[3:0]) : int'(exp_pair[7:4]));
        end
    end

    // One driver cycle; records a transaction when a handshake will occur.
    task automatic drive(input bit v, input int tv, input int hv, output bit hs);
        txn_t e;
        @(negedge clk);
        sample_valid = v;
        temp_in = 8'(tv);
        hum_in  = 8'(hv);
        hs = v && sample_ready && rst_n;
        if (hs) begin
            e.tpair = ref_pair(tv);
            e.hpair = ref_pair(hv);
            e.hs_t  = t;
            e.lat   = conv_time(tv) + conv_time(hv) + 2;
            e.tv    = tv;
            e.hv    = hv;
            q.push_back(e);
        end
    endtask

    task automatic send(input int tv, input int hv);
        bit hs;
        hs = 1'b0;
        for (int i = 0; i < 40 && !hs; i++) drive(1'b1, tv, hv, hs);
        if (!hs) chk("handshake_timeout", 0, 1);
        drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), hs);
    endtask

    task automatic idle(input int n);
        bit hs;
        for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), hs);
    endtask

    function automatic int rand_val();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99);
    endfunction

    initial begin
        bit hs;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: dashes, dwell toggles at 8, 16, 24.
        idle(30);

        // Directed samples, including the boundary values.
        send(23, 68);  idle(20);
        send(0, 99);   idle(20);
        send(150, 100); idle(10);
        send(99, 0);   idle(5);
        send(100, 9);  idle(5);
        send(9, 255);  idle(5);

        // Valid held high with data changing every cycle.
        for (int i = 0; i < 200; i++) drive(1'b1, rand_val(), rand_val(), hs);
        idle(25);

        // Reset during the humidity conversion of 45/50.
        send(45, 50);
        idle(5);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        send(45, 50);
        idle(30);

        // Random valid pattern and values.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) != 0, rand_val(), rand_val(), hs);

        // Drain outstanding transactions.
        for (int i = 0; i < 60 && q.size() != 0; i++) idle(1);
        chk("drain_empty", q.size(), 0);
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
